snp_adapter: RTL and testbench
==============================

// Module: snp_adapter
// PURPOSE
//  Write-side counterpart of the forwarder adapter in the p3 (ping/pang/pong) packet buffer.
//  Sits between the snooper agent and the snooper port of the p3 controller and memory.
//  Claims a free buffer, registers packet words into memory and accumulates packet byte length.
//  On end-of-packet, hands the buffer back to the p3 controller with its final length.
// PARAMETERS
//  ADDR_WIDTH  10   packet-memory word address width
//  DATA_WIDTH  64   packet-memory word width, bits; multiple of 8
//  INC_WIDTH   4    width of per-word valid-byte count; holds 0..DATA_WIDTH/8
//  PLEN_WIDTH  32   accumulated packet byte-length width
// PORTS
//  clk            in   1           clock
//  rst            in   1           asynchronous, active-low reset
//  sn_addr        in   ADDR_WIDTH  snooper word address
//  sn_wr_data     in   DATA_WIDTH  snooper write data
//  sn_wr_en       in   1           snooper write strobe, one word per cycle
//  sn_byte_inc    in   INC_WIDTH   valid bytes in this word; sampled with sn_wr_en
//  sn_done        in   1           end of packet; may coincide with the last sn_wr_en
//  sn_rdy         out  1           buffer owned, writes accepted
//  rdy_for_sn     in   1           p3 controller: a buffer is free for the snooper
//  rdy_for_sn_ack out  1           one-cycle pulse: adapter claims that buffer
//  mem_addr       out  ADDR_WIDTH  registered write address to packet memory
//  mem_wr_data    out  DATA_WIDTH  registered write data
//  mem_wr_en      out  1           registered write enable
//  sn_done_out    out  1           one-cycle pulse: buffer filled, byte_length valid
//  byte_length    out  PLEN_WIDTH  final packet length; valid while sn_done_out=1
//  drop_sticky    out  1           a write or done arrived while no buffer was owned; cleared only by reset
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; every output 0; length accumulator 0.
//   Any in-flight packet is abandoned; the p3 controller reclaims the buffer.
//  FSM states: IDLE, ARMED, FINISH.
//   IDLE:   sn_rdy=0. If rdy_for_sn=1: assert rdy_for_sn_ack for this one cycle, go to ARMED.
//   ARMED:  sn_rdy=1. Every sn_wr_en is forwarded with 1-cycle latency on mem_*.
//           Accumulator += sn_byte_inc, zero-extended; saturates at 2^PLEN_WIDTH-1.
//           On sn_done=1, go to FINISH.
//   FINISH: sn_rdy=0. sn_done_out=1 and byte_length=accumulator for this one cycle.
//           Then clear the accumulator and go to IDLE. Earliest re-claim is the cycle after FINISH.
//  Same-cycle sn_wr_en and sn_done in ARMED: the word is written and counted in byte_length.
//   Its mem_wr_en appears in the FINISH cycle, together with sn_done_out.
//   The p3 controller samples both on the same edge.
//  sn_wr_en or sn_done while not ARMED: ignored. No mem write, accumulator unchanged, drop_sticky<=1.
//  sn_done with no preceding writes: FINISH with byte_length=0.
//  sn_byte_inc > DATA_WIDTH/8: clamp to DATA_WIDTH/8.
//  mem_addr passes sn_addr through unchanged; the adapter does no address wrap or range check.
//  mem_wr_en=0 in every cycle without an accepted write; mem_addr and mem_wr_data hold their last values.
// STRUCTURE
//  Shared include p3_defs.vh: default widths and the state encodings
//   IDLE=2'd0, ARMED=2'd1, FINISH=2'd2.
//  One natural sub-module: plen_accum, the saturating length accumulator with clear.
//  FSM and the write register stage stay in snp_adapter.
// TESTING
//  1. Reset, rdy_for_sn=1 at cycle 3
//     -> rdy_for_sn_ack pulses at cycle 3; sn_rdy=1 from cycle 4.
//  2. Armed; 3 words at addr 0,1,2, inc 8,8,5; sn_done with the third word
//     -> 3 mem writes, each 1 cycle later; sn_done_out with byte_length=21 in the cycle of the 3rd mem write.
//  3. Idle, sn_wr_en=1 at addr 7
//     -> no mem_wr_en; drop_sticky=1; a later packet still yields the correct length.
//  4. PLEN_WIDTH=4; 3 words of inc 8
//     -> byte_length=15 (saturated).
//  5. rst=0 mid-packet after 2 words
//     -> all outputs 0 at once; after release, no sn_done_out until re-armed and a new sn_done.
//  6. Back-to-back packets, rdy_for_sn held 1
//     -> FINISH, IDLE/ack, ARMED in consecutive cycles; 2nd length excludes 1st packet's bytes.

Source files
------------

// File: rtl/snp_adapter_pkg.sv
// Shared definitions for the p3 snooper-side adapter: default widths, FSM encoding
// and the per-word byte-count clamp.
package snp_adapter_pkg;

    localparam int unsigned P3_ADDR_WIDTH = 10;
    localparam int unsigned P3_DATA_WIDTH = 64;
    localparam int unsigned P3_INC_WIDTH  = 4;
    localparam int unsigned P3_PLEN_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FINISH = 2'd2
    } snp_state_e;

    function automatic int unsigned clamp_bytes(input int unsigned raw,
                                                input int unsigned max_bytes);
        return (raw > max_bytes) ? max_bytes : raw;
    endfunction

endpackage

// File: rtl/snp_adapter_plen_accum.sv
// Saturating packet byte-length accumulator with synchronous clear.
module plen_accum
    import snp_adapter_pkg::*;
#(
    parameter int unsigned INC_WIDTH  = P3_INC_WIDTH,
    parameter int unsigned PLEN_WIDTH = P3_PLEN_WIDTH,
    parameter int unsigned MAX_INC    = P3_DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  add_i,
    input  logic [INC_WIDTH-1:0]  inc_i,
    input  logic                  clr_i,
    output logic [PLEN_WIDTH-1:0] len_o
);

    // One spare bit above the wider operand so the carry out is always visible.
    localparam int unsigned SW = ((PLEN_WIDTH > 32) ? PLEN_WIDTH : 32) + 1;
    localparam logic [SW-1:0] PMAX = SW'({PLEN_WIDTH{1'b1}});

    logic [PLEN_WIDTH-1:0] len_q, len_d;
    logic [SW-1:0]         sum;
    int unsigned           inc_clamped;

    always_comb begin
        inc_clamped = clamp_bytes(32'(inc_i), MAX_INC);
        sum         = SW'(len_q) + SW'(inc_clamped);
        len_d       = len_q;
        if (clr_i) begin
            len_d = '0;
        end else if (add_i) begin
            len_d = (sum > PMAX) ? '1 : sum[PLEN_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

    assign len_o = len_q;

endmodule

// File: rtl/snp_adapter.sv
// Snooper-side adapter of the p3 packet buffer: claims a free buffer, registers
// packet words into memory, and returns the buffer with its final byte length.
module snp_adapter
    import snp_adapter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = P3_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = P3_DATA_WIDTH,
    parameter int unsigned INC_WIDTH  = P3_INC_WIDTH,
    parameter int unsigned PLEN_WIDTH = P3_PLEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] sn_addr,
    input  logic [DATA_WIDTH-1:0] sn_wr_data,
    input  logic                  sn_wr_en,
    input  logic [INC_WIDTH-1:0]  sn_byte_inc,
    input  logic                  sn_done,
    output logic                  sn_rdy,
    input  logic                  rdy_for_sn,
    output logic                  rdy_for_sn_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    output logic                  sn_done_out,
    output logic [PLEN_WIDTH-1:0] byte_length,
    output logic                  drop_sticky
);

    snp_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  drop_q, drop_d;
    logic                  accept;
    logic                  clr;
    logic [PLEN_WIDTH-1:0] accum_len;

    always_comb begin
        state_d        = state_q;
        sn_rdy         = 1'b0;
        rdy_for_sn_ack = 1'b0;
        sn_done_out    = 1'b0;
        accept         = 1'b0;
        clr            = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rdy_for_sn) begin
                    // Held low during reset so no claim escapes while the FSM is forced idle.
                    rdy_for_sn_ack = rst;
                    state_d        = ARMED;
                end
            end
            ARMED: begin
                sn_rdy = 1'b1;
                accept = sn_wr_en;
                if (sn_done) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                sn_done_out = 1'b1;
                clr         = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en_d = accept;
        addr_d  = accept ? sn_addr    : addr_q;
        data_d  = accept ? sn_wr_data : data_q;
        drop_d  = drop_q | ((sn_wr_en | sn_done) & (state_q != ARMED));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            drop_q  <= drop_d;
        end
    end

    plen_accum #(
        .INC_WIDTH  (INC_WIDTH),
        .PLEN_WIDTH (PLEN_WIDTH),
        .MAX_INC    (DATA_WIDTH / 8)
    ) u_plen_accum (
        .clk_i  (clk),
        .rst_ni (rst),
        .add_i  (accept),
        .inc_i  (sn_byte_inc),
        .clr_i  (clr),
        .len_o  (accum_len)
    );

    assign mem_addr    = addr_q;
    assign mem_wr_data = data_q;
    assign mem_wr_en   = wr_en_q;
    assign byte_length = sn_done_out ? accum_len : '0;
    assign drop_sticky = drop_q;

endmodule

// File: tb/tb_snp_adapter.sv
// Directed bench for snp_adapter: a reference model pushes expected writes/lengths
// to queues which are popped as the DUTs (32-bit and 4-bit length) produce them.
module tb_snp_adapter;

    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int IW  = 4;
    localparam int PW  = 32;
    localparam int PW2 = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] sn_addr;
    logic [DW-1:0] sn_wr_data;
    logic          sn_wr_en;
    logic [IW-1:0] sn_byte_inc;
    logic          sn_done;
    logic          rdy_for_sn;

    logic          sn_rdy, rdy_for_sn_ack, mem_wr_en, sn_done_out, drop_sticky;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [PW-1:0] byte_length;

    logic           d2_rdy, d2_ack, d2_wr_en, d2_done, d2_drop;
    logic [AW-1:0]  d2_addr;
    logic [DW-1:0]  d2_data;
    logic [PW2-1:0] d2_len;

    always #5 clk = ~clk;

    snp_adapter #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .INC_WIDTH (IW), .PLEN_WIDTH (PW)
    ) dut (
        .clk (clk), .rst (rst), .sn_addr (sn_addr), .sn_wr_data (sn_wr_data),
        .sn_wr_en (sn_wr_en), .sn_byte_inc (sn_byte_inc), .sn_done (sn_done),
        .sn_rdy (sn_rdy), .rdy_for_sn (rdy_for_sn), .rdy_for_sn_ack (rdy_for_sn_ack),
        .mem_addr (mem_addr), .mem_wr_data (mem_wr_data), .mem_wr_en (mem_wr_en),
        .sn_done_out (sn_done_out), .byte_length (byte_length), .drop_sticky (drop_sticky)
    );

    snp_adapter #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .INC_WIDTH (IW), .PLEN_WIDTH (PW2)
    ) dut_p4 (
        .clk (clk), .rst (rst), .sn_addr (sn_addr), .sn_wr_data (sn_wr_data),
        .sn_wr_en (sn_wr_en), .sn_byte_inc (sn_byte_inc), .sn_done (sn_done),
        .sn_rdy (d2_rdy), .rdy_for_sn (rdy_for_sn), .rdy_for_sn_ack (d2_ack),
        .mem_addr (d2_addr), .mem_wr_data (d2_data), .mem_wr_en (d2_wr_en),
        .sn_done_out (d2_done), .byte_length (d2_len), .drop_sticky (d2_drop)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        int              cyc;
        longint unsigned len;
        longint unsigned len2;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int m_state = 0;   // 0 idle, 1 armed, 2 finish
    longint unsigned macc  = 0;
    longint unsigned macc2 = 0;
    bit mdrop = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned sat_add(input longint unsigned a,
                                                input logic [IW-1:0] inc, input int w);
        longint unsigned i, mx, s;
        i  = (inc > 4'd8) ? 64'd8 : 64'(inc);
        mx = (64'd1 << w) - 64'd1;
        s  = a + i;
        return (s > mx) ? mx : s;
    endfunction

    task automatic tick();
        int  nxt;
        bit  exp_ack;
        wr_t w;
        dn_t d;
        #1;
        exp_ack = (m_state == 0) && rdy_for_sn;
        chk("ack", rdy_for_sn_ack, exp_ack);
        chk("ack_p4", d2_ack, exp_ack);
        nxt = m_state;
        if (m_state != 1 && (sn_wr_en || sn_done)) mdrop = 1'b1;
        case (m_state)
            0: if (rdy_for_sn) nxt = 1;
            1: begin
                if (sn_wr_en) begin
                    w.cyc = cyc + 1; w.addr = sn_addr; w.data = sn_wr_data;
                    wq.push_back(w);
                    macc  = sat_add(macc, sn_byte_inc, PW);
                    macc2 = sat_add(macc2, sn_byte_inc, PW2);
                end
                if (sn_done) begin
                    d.cyc = cyc + 1; d.len = macc; d.len2 = macc2;
                    dq.push_back(d);
                    nxt = 2;
                end
            end
            default: begin
                macc = 0; macc2 = 0; nxt = 0;
            end
        endcase
        @(posedge clk);
        #1;
        cyc++;
        m_state = nxt;
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            w = wq.pop_front();
            chk("mem_wr_en", mem_wr_en, 1);
            chk("mem_addr", mem_addr, w.addr);
            chk("mem_wr_data", mem_wr_data, w.data);
            chk("mem_wr_en_p4", d2_wr_en, 1);
            chk("mem_addr_p4", d2_addr, w.addr);
            chk("mem_wr_data_p4", d2_data, w.data);
        end else begin
            chk("mem_wr_en", mem_wr_en, 0);
            chk("mem_wr_en_p4", d2_wr_en, 0);
        end
        if (dq.size() > 0 && dq[0].cyc == cyc) begin
            d = dq.pop_front();
            chk("sn_done_out", sn_done_out, 1);
            chk("byte_length", byte_length, d.len);
            chk("sn_done_out_p4", d2_done, 1);
            chk("byte_length_p4", d2_len, d.len2);
        end else begin
            chk("sn_done_out", sn_done_out, 0);
            chk("sn_done_out_p4", d2_done, 0);
        end
        chk("sn_rdy", sn_rdy, (m_state == 1));
        chk("sn_rdy_p4", d2_rdy, (m_state == 1));
        chk("drop_sticky", drop_sticky, mdrop);
        chk("drop_sticky_p4", d2_drop, mdrop);
    endtask

    task automatic idle_in();
        sn_wr_en = 1'b0; sn_done = 1'b0; sn_byte_inc = '0;
    endtask

    task automatic drive(input bit wr, input int addr, input bit done, input int inc);
        sn_wr_en    = wr;
        sn_addr     = AW'(addr);
        sn_wr_data  = {$urandom, $urandom};
        sn_byte_inc = IW'(inc);
        sn_done     = done;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        m_state = 0; macc = 0; macc2 = 0; mdrop = 1'b0;
        wq.delete(); dq.delete();
        chk("rst_sn_rdy", sn_rdy, 0);
        chk("rst_ack", rdy_for_sn_ack, 0);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wr_data", mem_wr_data, 0);
        chk("rst_done", sn_done_out, 0);
        chk("rst_byte_length", byte_length, 0);
        chk("rst_drop", drop_sticky, 0);
        chk("rst_done_p4", d2_done, 0);
        chk("rst_len_p4", d2_len, 0);
        idle_in();
        rdy_for_sn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        sn_addr = '0; sn_wr_data = '0; rdy_for_sn = 1'b0;
        idle_in();
        #2;
        rdy_for_sn = 1'b1;
        do_reset();

        // Claim after reset
        tick(); tick();
        rdy_for_sn = 1'b1; tick(); rdy_for_sn = 1'b0;

        // Three words, done with the last: 8+8+5
        drive(1, 0, 0, 8); tick();
        drive(1, 1, 0, 8); tick();
        drive(1, 2, 1, 5); tick();
        idle_in(); tick();

        // Writes and done while idle are dropped
        drive(1, 7, 0, 3); tick();
        drive(0, 0, 1, 0); tick();
        idle_in(); tick();
        rdy_for_sn = 1'b1; tick(); rdy_for_sn = 1'b0;
        drive(1, 3, 0, 3); tick();
        drive(1, 4, 0, 15); tick();
        drive(0, 0, 1, 0); tick();
        idle_in(); tick();

        // Done with no writes
        rdy_for_sn = 1'b1; tick(); rdy_for_sn = 1'b0;
        drive(0, 0, 1, 0); tick();
        idle_in(); tick();

        // 3 x 8 bytes: saturates on the 4-bit instance
        rdy_for_sn = 1'b1; tick(); rdy_for_sn = 1'b0;
        drive(1, 8, 0, 8); tick();
        drive(1, 9, 0, 8); tick();
        drive(1, 10, 1, 8); tick();
        idle_in(); tick();

        // Reset mid-packet
        rdy_for_sn = 1'b1; tick(); rdy_for_sn = 1'b0;
        drive(1, 20, 0, 8); tick();
        drive(1, 21, 0, 8); tick();
        drive(1, 22, 0, 8);
        rdy_for_sn = 1'b1;
        do_reset();
        repeat (4) tick();
        rdy_for_sn = 1'b1; tick(); rdy_for_sn = 1'b0;
        drive(1, 30, 1, 6); tick();
        idle_in(); tick();

        // Back-to-back packets with rdy_for_sn held
        rdy_for_sn = 1'b1; tick();
        drive(1, 40, 1, 8); tick();
        idle_in(); tick();
        tick();
        drive(1, 41, 1, 4); tick();
        rdy_for_sn = 1'b0;
        idle_in(); tick();
        tick();

        chk("writes_outstanding", wq.size(), 0);
        chk("dones_outstanding", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
